// File: rtl/mem_arbiter_if.sv
// Bundle of the requester handshakes and the shared memory bus around mem_arbiter.
// The master modport is the arbiter side (drives the memory bus and acknowledges); slave is its environment.
interface mem_arbiter_if;
  logic        REQ0;
  logic        REQ1;
  logic        WE0;
  logic        WE1;
  logic [15:0] ADDR0;
  logic [15:0] ADDR1;
  logic [7:0]  WDATA0;
  logic [7:0]  WDATA1;
  logic        ACK0;
  logic        ACK1;
  logic [7:0]  RDATA0;
  logic [7:0]  RDATA1;
  logic [1:0]  GNT;
  logic        BUSY;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        MEM_OE_bar;
  logic        MEM_WE_bar;

  modport master (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
    output ACK0, ACK1, RDATA0, RDATA1, GNT, BUSY, MEM_ADDR, MEM_WDATA, MEM_OE_bar, MEM_WE_bar
  );

  modport slave (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
    input  ACK0, ACK1, RDATA0, RDATA1, GNT, BUSY, MEM_ADDR, MEM_WDATA, MEM_OE_bar, MEM_WE_bar
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 8-bit/16-bit memory bus.
// Every output is a register; the strobe is only ever low while the FSM sits in ACCESS.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           CLK,
  input logic           RST_bar,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic [1:0]  gnt_r, gnt_s;
  logic        last_r, last_s;
  logic        we_r, we_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        ack0_r, ack0_s;
  logic        ack1_r, ack1_s;
  logic [7:0]  rdata0_r, rdata0_s;
  logic [7:0]  rdata1_r, rdata1_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  wdata_r, wdata_s;
  logic        oe_bar_r, oe_bar_s;
  logic        we_bar_r, we_bar_s;
  logic        busy_r, busy_s;
  logic        win_s;

  // State register
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output decode; last_r = 1 after reset so port 0 wins the first tie
  always_comb begin
    state_s  = state_r;
    gnt_s    = gnt_r;
    last_s   = last_r;
    we_s     = we_r;
    cnt_s    = cnt_r;
    ack0_s   = 1'b0;
    ack1_s   = 1'b0;
    rdata0_s = rdata0_r;
    rdata1_s = rdata1_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    oe_bar_s = 1'b1;
    we_bar_s = 1'b1;
    win_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.REQ0 && bus.REQ1) begin
          win_s = ~last_r;
        end else if (bus.REQ1) begin
          win_s = 1'b1;
        end else begin
          win_s = 1'b0;
        end
        if (bus.REQ0 || bus.REQ1) begin
          state_s = ST_SETUP;
          gnt_s   = win_s ? 2'b10 : 2'b01;
          we_s    = win_s ? bus.WE1 : bus.WE0;
          addr_s  = win_s ? bus.ADDR1 : bus.ADDR0;
          wdata_s = win_s ? bus.WDATA1 : bus.WDATA0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s  = ST_ACCESS;
        cnt_s    = CNT_LOAD;
        oe_bar_s = we_r;
        we_bar_s = ~we_r;
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_DONE;
          ack0_s  = gnt_r[0];
          ack1_s  = gnt_r[1];
          if (!we_r && gnt_r[1]) begin
            rdata1_s = bus.MEM_RDATA;
          end else if (!we_r) begin
            rdata0_s = bus.MEM_RDATA;
          end else begin
            rdata0_s = rdata0_r;
          end
        end else begin
          state_s  = ST_ACCESS;
          cnt_s    = cnt_r - 4'd1;
          oe_bar_s = we_r;
          we_bar_s = ~we_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        gnt_s   = 2'b00;
        last_s  = gnt_r[1];
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 2'b00;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // Output and datapath registers; reset drops strobes and grant immediately
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      gnt_r    <= 2'b00;
      last_r   <= 1'b1;
      we_r     <= 1'b0;
      cnt_r    <= 4'd0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      rdata0_r <= 8'h00;
      rdata1_r <= 8'h00;
      addr_r   <= 16'h0000;
      wdata_r  <= 8'h00;
      oe_bar_r <= 1'b1;
      we_bar_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      gnt_r    <= gnt_s;
      last_r   <= last_s;
      we_r     <= we_s;
      cnt_r    <= cnt_s;
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      rdata0_r <= rdata0_s;
      rdata1_r <= rdata1_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      oe_bar_r <= oe_bar_s;
      we_bar_r <= we_bar_s;
      busy_r   <= busy_s;
    end
  end

  assign bus.GNT        = gnt_r;
  assign bus.BUSY       = busy_r;
  assign bus.ACK0       = ack0_r;
  assign bus.ACK1       = ack1_r;
  assign bus.RDATA0     = rdata0_r;
  assign bus.RDATA1     = rdata1_r;
  assign bus.MEM_ADDR   = addr_r;
  assign bus.MEM_WDATA  = wdata_r;
  assign bus.MEM_OE_bar = oe_bar_r;
  assign bus.MEM_WE_bar = we_bar_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_mem_arbiter;
  localparam int W = 2;

  logic CLK = 1'b0;
  logic RST_bar;
  mem_arbiter_if ifc();

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .CLK     (CLK),
    .RST_bar (RST_bar),
    .bus     (ifc)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Memory array behind the bus: combinational read, write on each edge the write strobe is low
  logic [7:0] mem [256];
  assign ifc.MEM_RDATA = mem[ifc.MEM_ADDR[7:0]];
  always @(posedge CLK) begin
    if (ifc.MEM_WE_bar === 1'b0) mem[ifc.MEM_ADDR[7:0]] <= ifc.MEM_WDATA;
  end

  // Reference model: one access = a timeline t = 0..W+1 counted in edges from the grant
  logic [7:0]  m_mem [256];
  bit          m_busy = 1'b0;
  int          m_t = 0;
  bit          m_port = 1'b0;
  bit          m_last = 1'b1;
  bit          m_we = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_wdata = 8'h00;
  logic [7:0]  m_rd0 = 8'h00;
  logic [7:0]  m_rd1 = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge RST_bar);
      if (!RST_bar) begin
        m_busy = 1'b0; m_t = 0; m_port = 1'b0; m_last = 1'b1; m_we = 1'b0;
        m_addr = 16'h0000; m_wdata = 8'h00; m_rd0 = 8'h00; m_rd1 = 8'h00;
      end else if (!m_busy) begin
        if (ifc.REQ0 || ifc.REQ1) begin
          if (ifc.REQ0 && ifc.REQ1) m_port = !m_last;
          else m_port = ifc.REQ1;
          m_busy  = 1'b1;
          m_t     = 0;
          m_we    = m_port ? ifc.WE1 : ifc.WE0;
          m_addr  = m_port ? ifc.ADDR1 : ifc.ADDR0;
          m_wdata = m_port ? ifc.WDATA1 : ifc.WDATA0;
        end
      end else begin
        m_t++;
        if (m_t == W + 1) begin
          if (m_we) m_mem[m_addr[7:0]] = m_wdata;
          else if (m_port) m_rd1 = m_mem[m_addr[7:0]];
          else m_rd0 = m_mem[m_addr[7:0]];
        end
        if (m_t == W + 2) begin
          m_busy = 1'b0;
          m_last = m_port;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("GNT",  32'(ifc.GNT), m_busy ? (m_port ? 32'h2 : 32'h1) : 32'h0);
        chk("BUSY", 32'(ifc.BUSY), 32'(m_busy));
        chk("OE_bar", 32'(ifc.MEM_OE_bar), 32'(!(m_busy && !m_we && m_t >= 1 && m_t <= W)));
        chk("WE_bar", 32'(ifc.MEM_WE_bar), 32'(!(m_busy && m_we && m_t >= 1 && m_t <= W)));
        chk("ACK0", 32'(ifc.ACK0), 32'(m_busy && m_t == W + 1 && !m_port));
        chk("ACK1", 32'(ifc.ACK1), 32'(m_busy && m_t == W + 1 && m_port));
        chk("RDATA0", 32'(ifc.RDATA0), 32'(m_rd0));
        chk("RDATA1", 32'(ifc.RDATA1), 32'(m_rd1));
        chk("MEM_ADDR", 32'(ifc.MEM_ADDR), 32'(m_addr));
        chk("MEM_WDATA", 32'(ifc.MEM_WDATA), 32'(m_wdata));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Wait for the grant of 'port', then count edges and strobe-low cycles up to its ACK
  task automatic run_until_ack(input bit port, output int edges, output int oe_lo, output int we_lo);
    logic [1:0] g;
    bit done;
    g = 2'b00; done = 1'b0; edges = 1; oe_lo = 0; we_lo = 0;
    for (int n = 0; n < 40 && g == 2'b00; n++) begin
      @(negedge CLK);
      g = ifc.GNT;
    end
    chk("grant_port", 32'(g), port ? 32'h2 : 32'h1);
    for (int n = 0; n < 40 && !done; n++) begin
      if (!ifc.MEM_OE_bar) oe_lo++;
      if (!ifc.MEM_WE_bar) we_lo++;
      done = port ? ifc.ACK1 : ifc.ACK0;
      if (!done) begin
        @(negedge CLK);
        edges++;
      end
    end
    chk("ack_seen", 32'(done), 32'h1);
  endtask

  int edges, oe_lo, we_lo;
  bit order [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit seen;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i * 37 + 5);
      m_mem[i] = 8'(i * 37 + 5);
    end
    mem[8'h34] = 8'hA5;
    m_mem[8'h34] = 8'hA5;
    ifc.REQ0 = 1'b0; ifc.REQ1 = 1'b0; ifc.WE0 = 1'b0; ifc.WE1 = 1'b0;
    ifc.ADDR0 = 16'h0000; ifc.ADDR1 = 16'h0000; ifc.WDATA0 = 8'h00; ifc.WDATA1 = 8'h00;

    // Reset held with a pending request: nothing may move
    RST_bar = 1'b0;
    ifc.REQ0 = 1'b1; ifc.WE0 = 1'b0; ifc.ADDR0 = 16'h1234;
    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_gnt", 32'(ifc.GNT), 32'h0);
    chk("rst_busy", 32'(ifc.BUSY), 32'h0);
    chk("rst_strobes", 32'({ifc.MEM_OE_bar, ifc.MEM_WE_bar}), 32'h3);
    chk("rst_addr", 32'(ifc.MEM_ADDR), 32'h0000);
    tick();
    RST_bar = 1'b1;

    // Single read from 16'h1234
    run_until_ack(1'b0, edges, oe_lo, we_lo);
    chk("read_ack_edge", 32'(edges), 32'h4);
    chk("read_oe_cycles", 32'(oe_lo), 32'h2);
    chk("read_we_cycles", 32'(we_lo), 32'h0);
    chk("read_rdata0", 32'(ifc.RDATA0), 32'hA5);
    chk("read_rdata1", 32'(ifc.RDATA1), 32'h00);
    tick();
    ifc.REQ0 = 1'b0;

    // Single write from port 1
    ifc.REQ1 = 1'b1; ifc.WE1 = 1'b1; ifc.ADDR1 = 16'h8000; ifc.WDATA1 = 8'h3C;
    run_until_ack(1'b1, edges, oe_lo, we_lo);
    chk("write_ack_edge", 32'(edges), 32'h4);
    chk("write_we_cycles", 32'(we_lo), 32'h2);
    chk("write_oe_cycles", 32'(oe_lo), 32'h0);
    tick();
    ifc.REQ1 = 1'b0;
    chk("write_addr_hold", 32'(ifc.MEM_ADDR), 32'h8000);
    chk("write_wdata_hold", 32'(ifc.MEM_WDATA), 32'h3C);
    chk("write_rdata0_kept", 32'(ifc.RDATA0), 32'hA5);

    // Contention: both held, port 0 first since port 1 was served last
    ifc.REQ0 = 1'b1; ifc.WE0 = 1'b0; ifc.ADDR0 = 16'h0011;
    ifc.REQ1 = 1'b1; ifc.WE1 = 1'b1; ifc.ADDR1 = 16'h0077; ifc.WDATA1 = 8'h5E;
    for (int i = 0; i < 6; i++) run_until_ack(order[i], edges, oe_lo, we_lo);
    tick();
    ifc.REQ0 = 1'b0; ifc.REQ1 = 1'b0;

    // Stability: address change and request drop during ACCESS are ignored
    tick();
    ifc.REQ0 = 1'b1; ifc.WE0 = 1'b0; ifc.ADDR0 = 16'h2234;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      seen = (ifc.GNT == 2'b01);
    end
    tick();
    ifc.REQ0 = 1'b0; ifc.ADDR0 = 16'hFFFF;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      seen = ifc.ACK0;
    end
    chk("stable_ack0", 32'(seen), 32'h1);
    chk("stable_addr", 32'(ifc.MEM_ADDR), 32'h2234);
    chk("stable_rdata0", 32'(ifc.RDATA0), 32'hA5);

    // Reset in the middle of a write strobe
    tick();
    ifc.REQ1 = 1'b1; ifc.WE1 = 1'b1; ifc.ADDR1 = 16'h0050; ifc.WDATA1 = 8'h99;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      seen = !ifc.MEM_WE_bar;
    end
    chk("midrst_strobe_seen", 32'(seen), 32'h1);
    #1 RST_bar = 1'b0;
    #1;
    chk("midrst_strobes", 32'({ifc.MEM_OE_bar, ifc.MEM_WE_bar}), 32'h3);
    chk("midrst_gnt", 32'(ifc.GNT), 32'h0);
    chk("midrst_ack1", 32'(ifc.ACK1), 32'h0);
    repeat (2) tick();
    RST_bar = 1'b1;
    run_until_ack(1'b1, edges, oe_lo, we_lo);
    chk("after_rst_ack_edge", 32'(edges), 32'h4);
    chk("after_rst_we_cycles", 32'(we_lo), 32'h2);
    tick();
    ifc.REQ1 = 1'b0;

    // Randomized traffic, including mid-access changes that must be ignored
    for (int i = 0; i < 400; i++) begin
      tick();
      ifc.REQ0   = ($urandom_range(0, 9) < 6);
      ifc.REQ1   = ($urandom_range(0, 9) < 6);
      ifc.WE0    = $urandom_range(0, 1) == 1;
      ifc.WE1    = $urandom_range(0, 1) == 1;
      ifc.ADDR0  = 16'($urandom);
      ifc.ADDR1  = 16'($urandom);
      ifc.WDATA0 = 8'($urandom);
      ifc.WDATA1 = 8'($urandom);
    end
    ifc.REQ0 = 1'b0; ifc.REQ1 = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
